// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker and the system-ID slave.
// Pure wiring: no latency of its own.
// The slave stalls the master with avm_waitrequest.
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads system-ID word 0 then timestamp word 1, compares both with build-time values, holds pass/fail.
// Zero-wait, zero read latency: done rises three cycles after the start request.
// avm_waitrequest holds address/read stable; the check aborts with timeout after TIMEOUT_CYCLES stalled edges.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h6722_3E72,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  sysid_boot_checker_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        id_ok,
  output logic                        ts_ok,
  output logic                        timeout,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Stall counter sized so TIMEOUT_CYCLES-1 is representable; it never wraps.
  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  // Latency counter covers 1..3 cycles; unused when READ_LATENCY is 0.
  localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  state_t            state, state_nxt;
  logic              pend, pend_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [1:0]        lat_cnt, lat_nxt;
  logic              rd, rd_nxt;
  logic              addr, addr_nxt;
  logic              busy_nxt, done_nxt, id_ok_nxt, ts_ok_nxt, timeout_nxt;
  logic [31:0]       id_value_nxt, ts_value_nxt;
  logic              cap_id, cap_ts;

  // Read strobe and word select come straight from flops so they stay glitch-free and stable.
  assign avm.avm_read    = rd;
  assign avm.avm_address = addr;

  // Next-state and next-output logic; every register has a hold default.
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    wait_nxt     = wait_cnt;
    lat_nxt      = lat_cnt;
    rd_nxt       = rd;
    addr_nxt     = addr;
    busy_nxt     = busy;
    done_nxt     = done;
    id_ok_nxt    = id_ok;
    ts_ok_nxt    = ts_ok;
    timeout_nxt  = timeout;
    id_value_nxt = id_value;
    ts_value_nxt = ts_value;
    cap_id       = 1'b0;
    cap_ts       = 1'b0;

    case (state)
      IDLE, DONE: begin
        // A start while busy never reaches here, so it is dropped rather than queued.
        if (pend || start) begin
          state_nxt   = RD_ID;
          pend_nxt    = 1'b0;
          rd_nxt      = 1'b1;
          addr_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
          id_ok_nxt   = 1'b0;
          ts_ok_nxt   = 1'b0;
          timeout_nxt = 1'b0;
          wait_nxt    = '0;
          lat_nxt     = '0;
        end
      end

      RD_ID, RD_TS: begin
        if (avm.avm_waitrequest) begin
          if (wait_cnt == WAIT_LAST) begin
            // Slave never answered: give up and report whichever words were not captured as bad.
            state_nxt   = DONE;
            rd_nxt      = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            timeout_nxt = 1'b1;
            wait_nxt    = '0;
            ts_ok_nxt   = 1'b0;
            if (state == RD_ID) begin
              id_ok_nxt = 1'b0;
            end
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          wait_nxt = '0;
          if (READ_LATENCY == 0) begin
            cap_id = (state == RD_ID);
            cap_ts = (state == RD_TS);
          end else begin
            state_nxt = (state == RD_ID) ? LAT_ID : LAT_TS;
            rd_nxt    = 1'b0;
            lat_nxt   = '0;
          end
        end
      end

      LAT_ID, LAT_TS: begin
        // Data is valid on the READ_LATENCY-th edge after the accept edge.
        if (lat_cnt == LAT_LAST) begin
          lat_nxt = '0;
          cap_id  = (state == LAT_ID);
          cap_ts  = (state == LAT_TS);
        end else begin
          lat_nxt = lat_cnt + 2'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (cap_id) begin
      id_value_nxt = avm.avm_readdata;
      id_ok_nxt    = (avm.avm_readdata == EXPECTED_ID);
      state_nxt    = RD_TS;
      rd_nxt       = 1'b1;
      addr_nxt     = 1'b1;
    end

    if (cap_ts) begin
      ts_value_nxt = avm.avm_readdata;
      ts_ok_nxt    = (avm.avm_readdata == EXPECTED_TS);
      state_nxt    = DONE;
      rd_nxt       = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b1;
    end
  end

  // State and result registers; reset drops the read strobe at once and rearms the auto-start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pend     <= AUTO_START;
      wait_cnt <= '0;
      lat_cnt  <= '0;
      rd       <= 1'b0;
      addr     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      wait_cnt <= wait_nxt;
      lat_cnt  <= lat_nxt;
      rd       <= rd_nxt;
      addr     <= addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      id_ok    <= id_ok_nxt;
      ts_ok    <= ts_ok_nxt;
      timeout  <= timeout_nxt;
      id_value <= id_value_nxt;
      ts_value <= ts_value_nxt;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: three instances (zero latency, short timeout, latency 2 / manual start).
// Each instance has a behavioural slave with programmable stall counts and data.
// Expected timing and flags come from a cycle-count model of the read sequence.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID  = 32'h0000_0000;
  localparam logic [31:0] EXP_TS  = 32'h6722_3E72;
  localparam logic [31:0] JUNK    = 32'hBAD0_0BAD;
  localparam int          LAT_B   = 2;
  localparam int          TO_B    = 8;
  localparam int          TO_DEF  = 255;
  localparam int          BUDGET  = 2000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_s  [3];
  logic [31:0] mem_id   [3];
  logic [31:0] mem_ts   [3];
  int          stall_id [3];
  int          stall_ts [3];

  logic        busy_s [3];
  logic        done_s [3];
  logic        idok_s [3];
  logic        tsok_s [3];
  logic        to_s   [3];
  logic        rd_s   [3];
  logic        addr_s [3];
  logic [31:0] idv_s  [3];
  logic [31:0] tsv_s  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 2) ? LAT_B : 0;
    localparam int T = (g == 1) ? TO_B : TO_DEF;
    localparam bit A = (g != 2);

    sysid_boot_checker_if bus ();
    int         cnt = 0;
    logic [3:0] pv = '0;
    logic [3:0] pa = '0;

    always @(posedge clock) begin
      if (!bus.avm_read || !bus.avm_waitrequest) cnt <= 0;
      else cnt <= cnt + 1;
      pv <= {pv[2:0], bus.avm_read & ~bus.avm_waitrequest};
      pa <= {pa[2:0], bus.avm_address};
    end

    assign bus.avm_waitrequest = bus.avm_read &&
                                 (cnt < (bus.avm_address ? stall_ts[g] : stall_id[g]));

    if (L == 0) begin : g_l0
      assign bus.avm_readdata = (bus.avm_read && !bus.avm_waitrequest) ?
                                (bus.avm_address ? mem_ts[g] : mem_id[g]) : JUNK;
    end else begin : g_ln
      assign bus.avm_readdata = pv[L-1] ? (pa[L-1] ? mem_ts[g] : mem_id[g]) : JUNK;
    end

    assign rd_s[g]   = bus.avm_read;
    assign addr_s[g] = bus.avm_address;

    sysid_boot_checker #(
      .EXPECTED_ID    (EXP_ID),
      .EXPECTED_TS    (EXP_TS),
      .READ_LATENCY   (L),
      .TIMEOUT_CYCLES (T),
      .AUTO_START     (A)
    ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start_s[g]),
      .avm      (bus),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .id_ok    (idok_s[g]),
      .ts_ok    (tsok_s[g]),
      .timeout  (to_s[g]),
      .id_value (idv_s[g]),
      .ts_value (tsv_s[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 2) ? LAT_B : 0;
  endfunction

  function automatic int to_of(input int i);
    return (i == 1) ? TO_B : TO_DEF;
  endfunction

  task automatic set_slave(input int i, input logic [31:0] id, input logic [31:0] ts,
                           input int s1, input int s2);
    mem_id[i]   = id;
    mem_ts[i]   = ts;
    stall_id[i] = s1;
    stall_ts[i] = s2;
  endtask

  // Runs one check on instance i (called at a negedge) and compares against the model.
  task automatic run(input string name, input int i, input bit do_start, input int extra_k);
    int L, T, s1, s2;
    int exp_edge, exp_rd0, exp_rd1, exp_lat;
    bit exp_to, exp_idok, exp_tsok, id_cap;
    int rd0, rd1, lat, edge_n;

    for (int w = 0; w < BUDGET && busy_s[i]; w++) @(negedge clock);

    L = lat_of(i);
    T = to_of(i);
    s1 = stall_id[i];
    s2 = stall_ts[i];
    exp_idok = (mem_id[i] == EXP_ID);
    exp_tsok = (mem_ts[i] == EXP_TS);
    exp_to = 1'b0;
    id_cap = 1'b1;
    if (s1 >= T) begin
      exp_edge = 1 + T; exp_rd0 = T; exp_rd1 = 0; exp_lat = 0;
      exp_to = 1'b1; exp_idok = 1'b0; exp_tsok = 1'b0; id_cap = 1'b0;
    end else if (s2 >= T) begin
      exp_edge = 2 + s1 + L + T; exp_rd0 = s1 + 1; exp_rd1 = T; exp_lat = L;
      exp_to = 1'b1; exp_tsok = 1'b0;
    end else begin
      exp_edge = 3 + s1 + s2 + 2 * L; exp_rd0 = s1 + 1; exp_rd1 = s2 + 1; exp_lat = 2 * L;
    end

    if (do_start) start_s[i] = 1'b1;
    rd0 = 0; rd1 = 0; lat = 0; edge_n = 0;
    for (int k = 1; k <= BUDGET && edge_n == 0; k++) begin
      @(posedge clock);
      @(negedge clock);
      start_s[i] = (k == extra_k);
      if (done_s[i]) begin
        edge_n = k;
      end else begin
        if (rd_s[i] && !addr_s[i]) rd0++;
        if (rd_s[i] && addr_s[i]) rd1++;
        if (busy_s[i] && !rd_s[i]) lat++;
      end
    end
    start_s[i] = 1'b0;

    check_val({name, ".done_edge"}, edge_n, exp_edge);
    check_val({name, ".rd_id_cycles"}, rd0, exp_rd0);
    check_val({name, ".rd_ts_cycles"}, rd1, exp_rd1);
    check_val({name, ".lat_cycles"}, lat, exp_lat);
    check_val({name, ".id_ok"}, idok_s[i], exp_idok);
    check_val({name, ".ts_ok"}, tsok_s[i], exp_tsok);
    check_val({name, ".timeout"}, to_s[i], exp_to);
    check_val({name, ".busy"}, busy_s[i], 1'b0);
    check_val({name, ".read_low"}, rd_s[i], 1'b0);
    if (id_cap) check_val({name, ".id_value"}, idv_s[i], mem_id[i]);
    if (!exp_to) check_val({name, ".ts_value"}, tsv_s[i], mem_ts[i]);
  endtask

  initial begin
    int          ri, smax, sa, sb;
    logic [31:0] va, vb;

    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      set_slave(i, EXP_ID, EXP_TS, 0, 0);
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 3; i++) begin
      check_val("rst.busy", busy_s[i], 1'b0);
      check_val("rst.done", done_s[i], 1'b0);
      check_val("rst.read", rd_s[i], 1'b0);
    end
    check_val("rst.id_ok", idok_s[0], 1'b0);
    check_val("rst.ts_value", tsv_s[0], 32'h0);

    reset_n = 1'b1;
    run("auto", 0, 1'b0, 0);
    check_val("manual_idle.busy", busy_s[2], 1'b0);
    check_val("manual_idle.done", done_s[2], 1'b0);

    set_slave(0, EXP_ID, 32'h6722_3E71, 0, 0);
    run("bad_ts", 0, 1'b1, 0);

    set_slave(0, EXP_ID, EXP_TS, 4, 4);
    run("stall4", 0, 1'b1, 0);

    set_slave(1, EXP_ID, EXP_TS, 1000, 1000);
    run("stuck", 1, 1'b1, 0);
    set_slave(1, EXP_ID, EXP_TS, TO_B - 1, 0);
    run("to_edge_ok", 1, 1'b1, 0);
    set_slave(1, EXP_ID, EXP_TS, 0, TO_B);
    run("to_in_ts", 1, 1'b1, 0);

    set_slave(2, EXP_ID, EXP_TS, 0, 0);
    run("lat2", 2, 1'b1, 3);

    // Reset while the timestamp read is stalled.
    set_slave(0, EXP_ID, EXP_TS, 0, 5);
    set_slave(1, EXP_ID, EXP_TS, 0, 0);
    start_s[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_s[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_val("mid.pre_read", rd_s[0], 1'b1);
    check_val("mid.pre_addr", addr_s[0], 1'b1);
    check_val("mid.pre_id_ok", idok_s[0], 1'b1);
    reset_n = 1'b0;
    #1;
    check_val("mid.read", rd_s[0], 1'b0);
    check_val("mid.busy", busy_s[0], 1'b0);
    check_val("mid.id_ok", idok_s[0], 1'b0);
    check_val("mid.done", done_s[0], 1'b0);
    check_val("mid.id_value", idv_s[0], 32'h0);
    set_slave(0, EXP_ID, EXP_TS, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run("after_rst", 0, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      ri = $urandom_range(0, 2);
      smax = (ri == 1) ? 12 : ((ri == 2) ? 3 : 6);
      va = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      vb = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      sa = $urandom_range(0, smax);
      sb = $urandom_range(0, smax);
      set_slave(ri, va, vb, sa, sb);
      run("rnd", ri, 1'b1, (ri == 2) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its 32-bit readdata.
- After reset, or on request, it reads word 0 (system ID) and then word 1 (timestamp).
- It compares both words against build-time expected values and presents pass/fail flags and the captured words to the boot/status logic.
- The flags let the CPU-less boot path refuse to start on a mismatched FPGA image.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value the ID word (address 0) must match.
- EXPECTED_TS, 32'h6722_3E72, value the timestamp word (address 1) must match.
- READ_LATENCY, 0, slave read latency in cycles: 0 = data valid in the accept cycle; 1..3 = data valid N cycles after the accept cycle.
- TIMEOUT_CYCLES, 255, maximum consecutive cycles with waitrequest high before the check is aborted; range 1..65535.
- AUTO_START, 1, when 1 a check starts automatically after reset release.

Ports:
- clock, in, 1, single clock for all logic.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to re-run the check.
- avm_address, out, 1, word select to the slave: 0 = ID, 1 = timestamp.
- avm_read, out, 1, read strobe.
- avm_waitrequest, in, 1, slave stall; tie to 0 for a zero-wait slave.
- avm_readdata, in, 32, read data from the slave.
- busy, out, 1, check in progress.
- done, out, 1, high while a completed result is held.
- id_ok, out, 1, captured ID equals EXPECTED_ID.
- ts_ok, out, 1, captured timestamp equals EXPECTED_TS.
- timeout, out, 1, last check was aborted by waitrequest timeout.
- id_value, out, 32, captured ID word.
- ts_value, out, 32, captured timestamp word.

Behaviour:
- Clock/reset: one clock, clock. reset_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, wait counter 0, latency counter 0, pending-start flag = AUTO_START.
- States:
  - IDLE: busy = 0.
  - RD_ID: avm_address = 0, avm_read = 1.
  - LAT_ID: avm_read = 0, counting latency.
  - RD_TS: avm_address = 1, avm_read = 1.
  - LAT_TS: avm_read = 0, counting latency.
  - DONE: busy = 0, done = 1.
- Start:
  - From IDLE or DONE: pending-start or start = 1 -> RD_ID.
  - On that edge: clear done, id_ok, ts_ok, timeout; set busy = 1; clear pending-start.
  - start while busy is ignored; no queuing.
- Read accept: a read is accepted on a rising edge where avm_read = 1 and avm_waitrequest = 0.
  - avm_address and avm_read are registered outputs and stay stable until accept.
- Data capture:
  - READ_LATENCY = 0: avm_readdata is captured on the accept edge.
  - READ_LATENCY = N > 0: after accept, go to LAT_x, count N cycles, and capture on the Nth edge after accept.
- ID word:
  - Capture into id_value.
  - id_ok = (avm_readdata == EXPECTED_ID), registered together with the capture.
  - Next state: RD_TS.
- Timestamp word:
  - Capture into ts_value.
  - ts_ok = (avm_readdata == EXPECTED_TS).
  - Next state: DONE.
- Latency: with READ_LATENCY = 0 and no waitrequest, done rises exactly 3 cycles after the start edge (RD_ID, RD_TS, DONE).
- Timeout:
  - The wait counter increments on each edge in RD_x with avm_waitrequest = 1, and resets to 0 on accept or on state change.
  - When the counter reaches TIMEOUT_CYCLES: drop avm_read; set timeout = 1, done = 1, and id_ok/ts_ok = 0 for any word not yet captured; go to DONE.
  - The counter is wide enough for TIMEOUT_CYCLES with no wrap.
- Hold: DONE holds all results until the next start. IDLE is reached only from reset when AUTO_START = 0.
- Reset mid-check: avm_read drops immediately (asynchronously) and all results clear. If AUTO_START = 1, the check reruns after release.
- Comparisons are full 32-bit equality; no masking.

Test Plan:
- AUTO_START = 1, zero-wait slave returning 0x0 at address 0 and 0x67223E72 at address 1, waitrequest = 0:
  - -> two reads at addresses 0 then 1 on consecutive cycles;
  - done = 1 three cycles after reset release;
  - id_ok = 1, ts_ok = 1, id_value = 0x0, ts_value = 0x67223E72.
- Slave returns 0x67223E71 at address 1, then a start pulse -> ts_ok = 0, id_ok = 1, done = 1, timeout = 0.
- waitrequest held high for 4 cycles on each read with TIMEOUT_CYCLES = 255 -> address/read stable throughout, done 11 cycles after start, both flags 1.
- waitrequest stuck high with TIMEOUT_CYCLES = 8 -> avm_read drops after 8 stalled cycles, timeout = 1, done = 1, id_ok = 0, ts_ok = 0.
- READ_LATENCY = 2, slave data delayed by 2 cycles:
  - -> capture of the correct words, avm_read low during the latency cycles;
  - done at cycle 7;
  - a start pulse during busy is ignored.
- reset_n asserted while in RD_TS -> avm_read, busy, and flags go to 0 immediately; a full check completes after release.
